// File: rtl/msg_arb_q.sv
// Buffered message arbiter: one FIFO per cache requester, round-robin drain with
// optional high-priority override, into a registered valid/ready output stage.
module msg_arb_q #(
    parameter int cache_num  = 1,
    parameter int addr_width = 32,
    parameter int fifo_depth = 4,
    parameter int prio_en    = 0,
    localparam int SRC_W     = (cache_num > 1) ? $clog2(cache_num) : 1,
    localparam int MSG_W     = 4 + 2 * $clog2(cache_num) + addr_width
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [cache_num-1:0]       msg_req,
    output logic [cache_num-1:0]       msg_gnt,
    input  logic [cache_num*MSG_W-1:0] msg,
    output logic                       msg_out_valid,
    input  logic                       msg_out_ready,
    output logic [MSG_W-1:0]           msg_out,
    output logic [SRC_W-1:0]           msg_out_src,
    output logic [cache_num-1:0]       fifo_empty
);

    localparam int PTR_W = $clog2(fifo_depth);
    localparam int CNT_W = PTR_W + 1;

    logic [MSG_W-1:0] mem    [cache_num][fifo_depth];
    logic [PTR_W-1:0] rd_ptr [cache_num];
    logic [PTR_W-1:0] wr_ptr [cache_num];
    logic [CNT_W-1:0] cnt    [cache_num];
    logic [MSG_W-1:0] head   [cache_num];

    logic [cache_num-1:0] full, empty, hi, cand, push, pop;
    logic [SRC_W-1:0]     rr_ptr, sel;
    logic                 sel_vld, load, do_pop;

    always_comb begin
        for (int i = 0; i < cache_num; i++) begin
            full[i]  = (cnt[i] == CNT_W'(fifo_depth));
            empty[i] = (cnt[i] == '0);
            head[i]  = mem[i][rd_ptr[i]];
            hi[i]    = ~empty[i] & head[i][MSG_W-1];
        end
    end

    assign msg_gnt    = ~full;
    assign fifo_empty = empty;
    assign push       = msg_req & ~full;
    assign cand       = ((prio_en != 0) && (|hi)) ? hi : ~empty;

    // rr_ptr holds the first index to search, i.e. last granted + 1.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        sel     = '0;
        sel_vld = 1'b0;
        for (int i = 0; i < cache_num; i++) begin
            if (!sel_vld && cand[i] && (i >= int'(rr_ptr))) begin
                sel_vld = 1'b1;
                sel     = SRC_W'(i);
            end
        end
        for (int i = 0; i < cache_num; i++) begin
            if (!sel_vld && cand[i] && (i < int'(rr_ptr))) begin
                sel_vld = 1'b1;
                sel     = SRC_W'(i);
            end
        end
    end

    assign load   = ~msg_out_valid | msg_out_ready;
    assign do_pop = load & sel_vld;

    always_comb begin
        pop = '0;
        for (int i = 0; i < cache_num; i++) begin
            pop[i] = do_pop && (int'(sel) == i);
        end
    end

    // NOTE: storage carries no reset; the counts alone say which entries are live.
    always_ff @(posedge clk) begin
        for (int i = 0; i < cache_num; i++) begin
            if (push[i]) mem[i][wr_ptr[i]] <= msg[i*MSG_W +: MSG_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < cache_num; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                cnt[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < cache_num; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
                case ({push[i], pop[i]})
                    2'b10:   cnt[i] <= cnt[i] + 1'b1;
                    2'b01:   cnt[i] <= cnt[i] - 1'b1;
                    default: cnt[i] <= cnt[i];
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msg_out_valid <= 1'b0;
            msg_out       <= '0;
            msg_out_src   <= '0;
            rr_ptr        <= '0;
        end else if (load) begin
            msg_out_valid <= sel_vld;
            if (sel_vld) begin
                msg_out     <= head[sel];
                msg_out_src <= sel;
                rr_ptr      <= (int'(sel) == cache_num - 1) ? '0 : sel + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_msg_arb_q.sv
// Directed bench for msg_arb_q (4 requesters, priority enabled); a scoreboard
// queue holds hand-ordered expected messages, a monitor checks every transfer.
module tb_msg_arb_q;

    localparam int N = 4;
    localparam int W = 40;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   msg_req;
    logic [N-1:0]   msg_gnt;
    logic [N*W-1:0] msg;
    logic           msg_out_valid;
    logic           msg_out_ready;
    logic [W-1:0]   msg_out;
    logic [1:0]     msg_out_src;
    logic [N-1:0]   fifo_empty;

    typedef struct packed {
        logic [1:0]   src;
        logic [W-1:0] m;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    msg_arb_q #(.cache_num(N), .addr_width(32), .fifo_depth(4), .prio_en(1)) dut (
        .clk(clk), .rst_n(rst_n), .msg_req(msg_req), .msg_gnt(msg_gnt), .msg(msg),
        .msg_out_valid(msg_out_valid), .msg_out_ready(msg_out_ready),
        .msg_out(msg_out), .msg_out_src(msg_out_src), .fifo_empty(fifo_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] mk(input logic p, input logic [6:0] tag, input logic [31:0] a);
        return {p, tag, a};
    endfunction

    task automatic set_msg(input int i, input logic [W-1:0] v);
        msg[i*W +: W] = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic expect_push(input logic [1:0] s, input logic [W-1:0] v);
        exp_t e;
        e.src = s;
        e.m   = v;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        msg_req       = '0;
        msg           = '0;
        msg_out_ready = 1'b1;
        rst_n         = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        tick();
    endtask

    // Monitor: a transfer happens at the next edge whenever valid & ready now.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && msg_out_valid && msg_out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_output", 64'(sb.size()), 64'd1);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sb_src", 64'(msg_out_src), 64'(e.src));
                    check("sb_msg", 64'(msg_out), 64'(e.m));
                end
            end
        end
    end

    initial begin
        logic [W-1:0] v;
        logic [W-1:0] bp [6];
        int           k;
        int           nvalid, first, last;
        logic         acc;

        msg_req       = '0;
        msg           = '0;
        msg_out_ready = 1'b1;
        rst_n         = 1'b0;
        #1;
        check("rst_valid", 64'(msg_out_valid), 64'd0);
        check("rst_empty", 64'(fifo_empty), 64'hF);
        check("rst_gnt", 64'(msg_gnt), 64'hF);
        check("rst_msg_out", 64'(msg_out), 64'd0);
        check("rst_src", 64'(msg_out_src), 64'd0);

        // Single message from requester 2, two-cycle latency.
        do_reset();
        v = mk(1'b0, 7'h12, 32'h0000_1000);
        set_msg(2, v);
        msg_req = 4'b0100;
        expect_push(2'd2, v);
        tick();
        msg_req = '0;
        sample();
        check("t1_cycle1_valid", 64'(msg_out_valid), 64'd0);
        tick();
        sample();
        check("t1_cycle2_valid", 64'(msg_out_valid), 64'd1);
        check("t1_cycle2_src", 64'(msg_out_src), 64'd2);
        check("t1_cycle2_msg", 64'(msg_out), 64'(v));
        tick();
        sample();
        check("t1_cycle3_valid", 64'(msg_out_valid), 64'd0);
        check("t1_drained", 64'(sb.size()), 64'd0);

        // Round-robin fairness: 4 requesters x 3 back-to-back messages.
        do_reset();
        nvalid = 0;
        first  = -1;
        last   = -1;
        for (int cyc = 0; cyc < 16; cyc++) begin
            if (cyc < 3) begin
                for (int i = 0; i < N; i++) begin
                    v = mk(1'b0, 7'(cyc), 32'h100 * i + cyc);
                    set_msg(i, v);
                    expect_push(2'(i), v);
                end
                msg_req = 4'hF;
            end else begin
                msg_req = '0;
            end
            tick();
            sample();
            if (msg_out_valid) begin
                nvalid++;
                if (first < 0) first = cyc;
                last = cyc;
            end
        end
        check("t2_valid_count", 64'(nvalid), 64'd12);
        check("t2_first_valid", 64'(first), 64'd1);
        check("t2_contiguous", 64'(last - first), 64'd11);
        check("t2_drained", 64'(sb.size()), 64'd0);

        // Backpressure: requester 1 fills its FIFO plus the output register.
        do_reset();
        msg_out_ready = 1'b0;
        for (int j = 0; j < 6; j++) bp[j] = mk(1'b0, 7'h30 + 7'(j), 32'hA000 + j);
        k = 0;
        set_msg(1, bp[0]);
        msg_req = 4'b0010;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            acc = msg_gnt[1];
            tick();
            if (acc) begin
                expect_push(2'd1, bp[k]);
                k++;
                set_msg(1, bp[k]);
            end
            if (cyc == 3) check("t3_stall_msg_mid", 64'(msg_out), 64'(bp[0]));
        end
        check("t3_accepts", 64'(k), 64'd5);
        check("t3_gnt", 64'(msg_gnt), 64'b1101);
        check("t3_stall_valid", 64'(msg_out_valid), 64'd1);
        check("t3_stall_msg", 64'(msg_out), 64'(bp[0]));
        check("t3_stall_src", 64'(msg_out_src), 64'd1);
        msg_req       = '0;
        msg_out_ready = 1'b1;
        for (int cyc = 0; cyc < 8; cyc++) tick();
        check("t3_drained", 64'(sb.size()), 64'd0);
        check("t3_gnt_after", 64'(msg_gnt), 64'hF);

        // Priority: FIFO 3 head is high priority, FIFO 0 head is not.
        do_reset();
        set_msg(0, mk(1'b0, 7'h40, 32'h0000_B000));
        set_msg(3, mk(1'b1, 7'h43, 32'h0000_B300));
        expect_push(2'd3, mk(1'b1, 7'h43, 32'h0000_B300));
        expect_push(2'd0, mk(1'b0, 7'h40, 32'h0000_B000));
        msg_req = 4'b1001;
        tick();
        msg_req = '0;
        tick();
        sample();
        check("t4_first_src", 64'(msg_out_src), 64'd3);
        for (int cyc = 0; cyc < 4; cyc++) tick();
        check("t4_drained", 64'(sb.size()), 64'd0);

        // Reset mid-stream with queued and registered messages.
        do_reset();
        msg_out_ready = 1'b0;
        for (int cyc = 0; cyc < 2; cyc++) begin
            for (int i = 0; i < N; i++) set_msg(i, mk(1'b0, 7'h50 + 7'(cyc), 32'hC000 + 16 * i));
            msg_req = 4'hF;
            tick();
        end
        msg_req = '0;
        tick();
        sample();
        check("t5_pre_valid", 64'(msg_out_valid), 64'd1);
        check("t5_pre_empty", 64'(fifo_empty), 64'h0);
        #1;
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", 64'(msg_out_valid), 64'd0);
        check("t5_rst_empty", 64'(fifo_empty), 64'hF);
        check("t5_rst_gnt", 64'(msg_gnt), 64'hF);
        check("t5_rst_msg_out", 64'(msg_out), 64'd0);
        sb.delete();
        @(negedge clk);
        rst_n         = 1'b1;
        msg_out_ready = 1'b1;
        tick();
        v = mk(1'b0, 7'h60, 32'h0000_D000);
        set_msg(0, v);
        msg_req = 4'b0001;
        expect_push(2'd0, v);
        tick();
        msg_req = '0;
        sample();
        check("t5_cycle1_valid", 64'(msg_out_valid), 64'd0);
        tick();
        sample();
        check("t5_cycle2_valid", 64'(msg_out_valid), 64'd1);
        check("t5_cycle2_src", 64'(msg_out_src), 64'd0);
        check("t5_cycle2_msg", 64'(msg_out), 64'(v));
        tick();
        sample();
        check("t5_drained", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/msg_arb_q.md
Name: msg_arb_q

Overview:
Buffered, backpressure-aware successor to the single-cycle message arbiter. Each of cache_num cache-side requesters feeds a private FIFO. A round-robin arbiter, with optional two-level priority, drains the FIFOs into a registered output stage. The output uses a valid/ready handshake, so the downstream directory/bus can stall without losing messages.

Parameters:
- cache_num, 1, number of requesting caches.
- addr_width, 32, address field width inside a message.
- fifo_depth, 4, entries per input FIFO; power of 2, >=2.
- prio_en, 0, 1 = message bit MSG_W-1 marks a high-priority message.
- Localparam SRC_W = max(1, $clog2(cache_num)).
- Localparam MSG_W = 4 + 2*$clog2(cache_num) + addr_width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- msg_req  in  cache_num  per-requester message valid.
- msg_gnt  out  cache_num  per-requester accept (FIFO not full).
- msg  in  cache_num*MSG_W  packed messages; requester i occupies bits [i*MSG_W +: MSG_W].
- msg_out_valid  out  1  output message valid.
- msg_out_ready  in  1  downstream accept.
- msg_out  out  MSG_W  granted message.
- msg_out_src  out  SRC_W  index of the requester that sourced msg_out.
- fifo_empty  out  cache_num  per-FIFO empty flag, registered state.

Behaviour:
- Reset (async assert, sync-released by the clk domain): all FIFO pointers and counts = 0; fifo_empty = all 1; msg_gnt = all 1; msg_out_valid = 0; msg_out = 0; msg_out_src = 0; round-robin pointer = 0.
- msg_gnt[i] = ~full[i]. It depends only on registered state and has no combinational path from msg_req or msg_out_ready.
- Push[i] = msg_req[i] & msg_gnt[i]. msg[i] is written into FIFO i on that edge. A requester holds msg stable while msg_req is high and msg_gnt is low.
- Output register load condition: load = ~msg_out_valid | msg_out_ready.
- Pop: when load is true and at least one FIFO is non-empty, the arbiter-selected FIFO head is popped and written into msg_out/msg_out_src, and msg_out_valid is set to 1.
- Idle: when load is true and all FIFOs are empty, msg_out_valid goes to 0.
- Stall: when msg_out_valid=1 and msg_out_ready=0, msg_out, msg_out_src and msg_out_valid hold, and no FIFO pops.
- Arbitration, prio_en=0: round-robin over non-empty FIFOs. Search starts at index (last_granted+1) mod cache_num. The pointer updates only on a pop.
- Arbitration, prio_en=1: candidate set = non-empty FIFOs whose head has bit MSG_W-1 set. If that set is empty, the candidate set is all non-empty FIFOs. Round-robin over the candidate set uses the same single pointer.
- Latency: a message pushed at edge t is visible on msg_out in the cycle after edge t+1 (2 cycles), provided it wins arbitration and the output register is free.
- Throughput: 1 message/cycle sustained while msg_out_ready=1.
- A full FIFO blocks only its own requester; the other requesters are unaffected.
- Push and pop on the same FIFO in the same edge are both honoured and the count is unchanged. A push into an empty FIFO is not bypassed to the output in the same cycle.
- Pointers wrap modulo fifo_depth. Count width is $clog2(fifo_depth)+1 to distinguish full from empty.
- cache_num=1: arbiter degenerates to FIFO 0; msg_out_src = 0.
- Reset mid-operation flushes all queued and registered messages. No partial message is ever presented.

Test Plan:
- Single message: cache_num=4, req[2] with addr 0x1000 at cycle 0, ready=1 -> msg_out_valid=1 at cycle 2, msg_out_src=2, payload exact; valid=0 at cycle 3.
- Round-robin fairness: all 4 requesters push 3 messages each back-to-back, ready=1 -> output src order 0,1,2,3,0,1,2,3,0,1,2,3; 12 consecutive valid cycles.
- Backpressure/full: ready=0, requester 1 pushes continuously -> msg_gnt[1] drops after 4 accepts (depth 4) plus 1 held in the output register; msg_out stable. Raise ready -> remaining 5 delivered in order, no loss or duplication.
- Priority: prio_en=1, FIFO 0 head low-priority, FIFO 3 head high-priority, both queued -> src 3 emitted first, then 0.
- Reset mid-stream: async rst_n low mid-cycle with queues non-empty -> msg_out_valid=0 immediately, fifo_empty all 1, msg_gnt all 1. After release, a new message on req[0] emerges with src 0 at cycle 2.
